// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared size encodings, response-entry layout and latency bound for the SRAM-like responder
package sram_like_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int LATENCY_MAX = 7;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [2:0]  age;
  } resp_entry_t;
endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// resp_queue: circular FIFO of response entries; every stored age counts down each edge and the head pops when it reaches 0
// Ports: clk, resetn (sync, active-low), push/push_entry (enqueue at tail), head (oldest entry),
//        head_ready (head age is 0, pops at this edge), full (no free slot).
module resp_queue
  import sram_like_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  resp_entry_t push_entry,
  output resp_entry_t head,
  output logic        head_ready,
  output logic        full
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  resp_entry_t q [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(QUEUE_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = q[rd_ptr];
  assign head_ready = count != '0 && head.age == '0;
  assign full = count == CW'(QUEUE_DEPTH);
  // Empty slots also age; harmless because count gates head_ready and pushes overwrite the slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (q[i].age != '0) q[i].age <= q[i].age - 3'd1;
      if (push) begin
        q[wr_ptr] <= push_entry;
        wr_ptr    <= inc(wr_ptr);
      end
      if (head_ready) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(head_ready);
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: fixed-latency, in-order SRAM-like memory responder with byte-strobed writes
// Ports: clk, resetn (sync, active-low); request side req/wr/size/addr/wstrb/wdata with addr_ok handshake;
//        response side data_ok pulse with rdata (0 for write responses and when idle).
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int LATENCY        = 2,
  parameter int QUEUE_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("LATENCY must be within 1..7");
  end
  logic [31:0] mem [2**MEM_DEPTH_LOG2];
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic resetn_q, full, accept, head_ready;
  resp_entry_t head, push_entry;
  logic unused_bits;
  assign idx = addr[MEM_DEPTH_LOG2+1:2];
  assign addr_ok = resetn_q && !full;
  assign accept = req && addr_ok && resetn;
  // Reads capture the word at acceptance; earlier writes already landed, so no forwarding is needed.
  assign push_entry = '{wr: wr, size: size, data: wr ? '0 : mem[idx], age: 3'(LATENCY - 1)};
  // Response outputs decode straight from the queue flops, so they change only on clock edges.
  assign data_ok = head_ready;
  assign rdata = head_ready && !head.wr ? head.data : '0;
  assign unused_bits = ^{addr[31:MEM_DEPTH_LOG2+2], addr[1:0], head.size, head.age};
  always_ff @(posedge clk) resetn_q <= resetn;
  always_ff @(posedge clk)
    if (accept && wr)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  resp_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_entry(push_entry),
    .head      (head),
    .head_ready(head_ready),
    .full      (full)
  );
endmodule
